sa_tile_sequencer: RTL
======================

// Module: sa_tile_sequencer
// PURPOSE
//   Parametrised NxN systolic-array sequencer: on start, streams one NxK A tile and one KxN B
//   tile out of N-lane A/B SRAM banks with diagonal skew. It then drains the PE array and writes
//   the NxN C tile into N C banks row by row. It replaces the fixed 4-lane, fixed-depth address
//   control in the array top: the inner dimension k_len and all base addresses are runtime inputs.
// PARAMETERS
//   N       4   array dimension = lanes per bank group
//   DATA_W  8   element width (A/B/C)
//   ADDR_W  11  per-bank SRAM address width
//   K_W     11  width of k_len
// PORTS
//   clk      in   1         clock
//   rst_n    in   1         synchronous active-low reset
//   start    in   1         request; sampled only in IDLE
//   k_len    in   K_W       inner dimension K; latched with start
//   a_base   in   ADDR_W    A start address; latched with start
//   b_base   in   ADDR_W    B start address; latched with start
//   c_base   in   ADDR_W    C row-0 address; latched with start
//   addrA    out  N*ADDR_W  lane i at [i*ADDR_W +: ADDR_W]; lane i = row i of A
//   addrB    out  N*ADDR_W  lane j = column j of B
//   a_vld    out  N         lane i SRAM data valid (1-cycle read latency applied); PE gets 0 when low
//   b_vld    out  N         as a_vld, for B
//   pe_clear out  1         clears PE accumulators
//   row_sel  out  $clog2(N) PE row muxed onto COUT during WRITE
//   addrC    out  N*ADDR_W  C lane j address
//   wenC     out  N         C bank write enable, active low (1 = read/idle)
//   busy     out  1         high from the cycle after start acceptance until finish
//   finish   out  1         one-cycle completion pulse
// BEHAVIOUR
//   Reset: state IDLE. addrA/addrB/addrC = 0. a_vld/b_vld = 0. wenC = all 1. pe_clear/busy/finish = 0.
//     row_sel = 0. A reset in any state aborts the tile; the next cycle shows the reset values.
//     No write is issued after reset.
//   States: IDLE -> FEED -> DRAIN -> WRITE -> DONE -> IDLE. All outputs are registered.
//   IDLE: start=1 latches the inputs. Next state is FEED, or DONE if k_len==0.
//     k_len==0: no reads or writes; pe_clear pulses with finish.
//   FEED: lasts K+N-1 cycles, local counter t = 0..K+N-2.
//     pe_clear = 1 only at t==0.
//     Lane i: addrA = a_base + (t-i) and addrB = b_base + (t-i) when 0 <= t-i < K; otherwise the
//     address holds its last value.
//     a_vld[i]/b_vld[i] = the in-window condition delayed 1 cycle, which matches SRAM latency.
//   DRAIN: 2N-1 cycles, all vld = 0. Covers the last-operand propagation plus the 1-cycle SRAM lag.
//   WRITE: N cycles, r = 0..N-1. row_sel = r, every addrC lane = c_base + r, wenC = all 0.
//   DONE: 1 cycle. finish = 1, busy = 0. Returns to IDLE; start can be accepted the next cycle.
//   Address arithmetic: modulo 2^ADDR_W, so base + offset wraps silently.
//   start while not IDLE is ignored. Inputs are not re-sampled mid-tile.
//   Latency: start sampled at cycle 0 -> finish at cycle K+4N-1 (K>=1); k_len==0 -> finish at cycle 1.
// STRUCTURE
//   Package sa_pkg: state enum (IDLE, FEED, DRAIN, WRITE, DONE), DRAIN_CYC = 2*N-1, lane-slice helper.
//   Sub-module sa_skew_lane: one lane's window test (lane index i, t, K), address adder and 1-cycle
//     valid delay. Instantiated N times each for A and B through generate.
//   The top holds the FSM, counter t, row counter r and the latched config.
// TESTING
//   1 Reset: hold rst_n=0 for 3 cycles mid-FEED -> next cycle wenC=4'hF, busy=0, all vld=0;
//     no C write ever occurs.
//   2 N=4, K=4, all bases 0 -> lane0 addrA 0,1,2,3 at t=0..3; lane3 addrA 0..3 at t=3..6;
//     a_vld[3] high at t=4..7; finish at cycle 19.
//   3 Same tile, c_base=100 -> wenC=0 for exactly 4 cycles with addrC=100..103, row_sel=0..3,
//     then finish.
//   4 K=1 -> each lane gets one read at t=i; finish at cycle 16. k_len=0 -> finish at cycle 1,
//     no wenC low.
//   5 a_base=2047, K=4 -> lane0 addrA = 2047,0,1,2 (wrap).
//   6 start pulsed during FEED and WRITE is ignored (single finish). start the cycle after finish
//     -> second tile runs with identical timing.

Source files
------------

// File: rtl/sa_pkg.sv
// Shared types and helpers for the systolic-array tile sequencer.
// Holds the FSM state encoding, the drain-length helper and the lane-slice helper.
package sa_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FEED,
        DRAIN,
        WRITE,
        DONE
    } state_t;

    // Drain covers last-operand propagation across the array plus the SRAM lag.
    function automatic int drain_cyc(input int n);
        return 2 * n - 1;
    endfunction

    // Low bit of lane `lane` inside a packed bus of `w`-bit lanes.
    function automatic int lane_lo(input int lane, input int w);
        return lane * w;
    endfunction

endpackage

// File: rtl/sa_skew_lane.sv
// One skewed operand lane: window test, address adder and valid delay.
// The valid follows the address by one cycle to line up with SRAM read data.
module sa_skew_lane #(
    parameter int LANE   = 0,
    parameter int ADDR_W = 11,
    parameter int K_W    = 11,
    parameter int CNT_W  = 14
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              feed,
    input  logic [CNT_W-1:0]  t,
    input  logic [K_W-1:0]    k,
    input  logic [ADDR_W-1:0] base,
    output logic [ADDR_W-1:0] addr,
    output logic              vld
);

    logic [CNT_W-1:0] off;
    logic             win;
    logic             win_q;

    // Lane is inside its window when 0 <= t-LANE < K during FEED.
    always_comb begin
        off = t - CNT_W'(LANE);
        win = feed && (t >= CNT_W'(LANE)) && (off < CNT_W'(k));
    end

    // Address updates only inside the window, else holds; valid lags by one.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr  <= '0;
            win_q <= 1'b0;
            vld   <= 1'b0;
        end else begin
            if (win) begin
                addr <= base + ADDR_W'(off);
            end
            win_q <= win;
            vld   <= win_q;
        end
    end

endmodule

// File: rtl/sa_tile_sequencer.sv
// NxN systolic-array tile sequencer: skewed A/B feed, drain, row-wise C write.
// FSM, feed/drain counter, row counter and latched tile config live here.
module sa_tile_sequencer
    import sa_pkg::*;
#(
    parameter int N      = 4,
    parameter int DATA_W = 8,
    parameter int ADDR_W = 11,
    parameter int K_W    = 11
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [K_W-1:0]         k_len,
    input  logic [ADDR_W-1:0]      a_base,
    input  logic [ADDR_W-1:0]      b_base,
    input  logic [ADDR_W-1:0]      c_base,
    output logic [N*ADDR_W-1:0]    addrA,
    output logic [N*ADDR_W-1:0]    addrB,
    output logic [N-1:0]           a_vld,
    output logic [N-1:0]           b_vld,
    output logic                   pe_clear,
    output logic [$clog2(N)-1:0]   row_sel,
    output logic [N*ADDR_W-1:0]    addrC,
    output logic [N-1:0]           wenC,
    output logic                   busy,
    output logic                   finish
);

    localparam int RS_W      = $clog2(N);
    localparam int CNT_W     = K_W + RS_W + 1;
    localparam int DRAIN_CYC = drain_cyc(N);

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  t, t_nxt;
    logic [RS_W-1:0]   r, r_nxt;
    logic [K_W-1:0]    k_q;
    logic [ADDR_W-1:0] a_q, b_q, c_q;
    logic [CNT_W-1:0]  feed_last;
    logic              feed;

    assign feed      = (state == FEED);
    assign feed_last = CNT_W'(k_q) + CNT_W'(N) - CNT_W'(2);

    // State, counters and the tile config captured on start acceptance.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            t     <= '0;
            r     <= '0;
            k_q   <= '0;
            a_q   <= '0;
            b_q   <= '0;
            c_q   <= '0;
        end else begin
            state <= state_nxt;
            t     <= t_nxt;
            r     <= r_nxt;
            if (state == IDLE && start) begin
                k_q <= k_len;
                a_q <= a_base;
                b_q <= b_base;
                c_q <= c_base;
            end
        end
    end

    // Next-state and counter sequencing through the tile phases.
    always_comb begin
        state_nxt = state;
        t_nxt     = t;
        r_nxt     = r;
        unique case (state)
            IDLE: begin
                if (start) begin
                    t_nxt     = '0;
                    r_nxt     = '0;
                    state_nxt = (k_len == '0) ? DONE : FEED;
                end
            end
            FEED: begin
                if (t == feed_last) begin
                    state_nxt = DRAIN;
                    t_nxt     = '0;
                end else begin
                    t_nxt = t + 1'b1;
                end
            end
            DRAIN: begin
                if (t == CNT_W'(DRAIN_CYC - 1)) begin
                    state_nxt = WRITE;
                    r_nxt     = '0;
                end else begin
                    t_nxt = t + 1'b1;
                end
            end
            WRITE: begin
                if (r == RS_W'(N - 1)) begin
                    state_nxt = DONE;
                end else begin
                    r_nxt = r + 1'b1;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Registered control outputs decoded from the current phase.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pe_clear <= 1'b0;
            busy     <= 1'b0;
            finish   <= 1'b0;
            wenC     <= '1;
            row_sel  <= '0;
            addrC    <= '0;
        end else begin
            pe_clear <= (feed && t == '0) ||
                        (state == DONE && k_q == '0);
            busy     <= state inside {FEED, DRAIN, WRITE};
            finish   <= (state == DONE);
            wenC     <= (state == WRITE) ? '0 : '1;
            if (state == WRITE) begin
                row_sel <= r;
                addrC   <= {N{c_q + ADDR_W'(r)}};
            end
        end
    end

    for (genvar gi = 0; gi < N; gi++) begin : g_lane
        sa_skew_lane #(
            .LANE  (gi),
            .ADDR_W(ADDR_W),
            .K_W   (K_W),
            .CNT_W (CNT_W)
        ) u_a (
            .clk  (clk),
            .rst_n(rst_n),
            .feed (feed),
            .t    (t),
            .k    (k_q),
            .base (a_q),
            .addr (addrA[lane_lo(gi, ADDR_W) +: ADDR_W]),
            .vld  (a_vld[gi])
        );

        sa_skew_lane #(
            .LANE  (gi),
            .ADDR_W(ADDR_W),
            .K_W   (K_W),
            .CNT_W (CNT_W)
        ) u_b (
            .clk  (clk),
            .rst_n(rst_n),
            .feed (feed),
            .t    (t),
            .k    (k_q),
            .base (b_q),
            .addr (addrB[lane_lo(gi, ADDR_W) +: ADDR_W]),
            .vld  (b_vld[gi])
        );
    end

endmodule
